// File: rtl/spi_master.sv
// SPI mode-0 master: one BITS-wide full-duplex word per start request, MSB first.
// sclk runs at clk/(2*CLK_DIV); ss_n is framed by CLK_DIV-cycle setup, hold and gap phases.
module spi_master #(
   parameter int BITS    = 8,
   parameter int CLK_DIV = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [BITS-1:0] txData,
   output logic [BITS-1:0] rxData,
   output logic            busy,
   output logic            done,
   output logic            ss_n,
   output logic            sclk,
   output logic            mosi,
   input  logic            miso
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(BITS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(BITS - 1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

   state_t          state, state_next;
   logic [CNT_W-1:0] half_cnt, half_cnt_d;
   logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
   logic [BITS-1:0]  tx_sr, tx_sr_d;
   logic [BITS-1:0]  rx_sr, rx_sr_d;
   logic [BITS-1:0]  rx_data_d;
   logic             busy_d, done_d, ss_n_d, sclk_d, mosi_d;
   logic             tick, last_bit;

   assign tick     = (half_cnt == CNT_MAX);
   assign last_bit = (bit_cnt == BIT_MAX);

   // NOTE: every register here uses <= so all state updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         half_cnt <= '0;
         bit_cnt  <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rxData   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ss_n     <= 1'b1;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
      end else begin
         state    <= state_next;
         half_cnt <= half_cnt_d;
         bit_cnt  <= bit_cnt_d;
         tx_sr    <= tx_sr_d;
         rx_sr    <= rx_sr_d;
         rxData   <= rx_data_d;
         busy     <= busy_d;
         done     <= done_d;
         ss_n     <= ss_n_d;
         sclk     <= sclk_d;
         mosi     <= mosi_d;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = SETUP;
         SETUP:   if (tick) state_next = XFER;
         XFER:    if (tick && sclk && last_bit) state_next = HOLD;
         HOLD:    if (tick) state_next = GAP;
         GAP:     if (tick) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: every target gets a hold default first, so no path can infer a latch.
   always_comb begin
      half_cnt_d = tick ? '0 : half_cnt + 1'b1;
      bit_cnt_d  = bit_cnt;
      tx_sr_d    = tx_sr;
      rx_sr_d    = rx_sr;
      rx_data_d  = rxData;
      busy_d     = busy;
      done_d     = 1'b0;
      ss_n_d     = ss_n;
      sclk_d     = sclk;
      mosi_d     = mosi;

      unique case (state)
         IDLE: begin
            half_cnt_d = '0;
            ss_n_d     = 1'b1;
            sclk_d     = 1'b0;
            mosi_d     = 1'b0;
            busy_d     = 1'b0;
            if (start) begin
               tx_sr_d   = txData;
               bit_cnt_d = '0;
               ss_n_d    = 1'b0;
               mosi_d    = txData[BITS-1];
               busy_d    = 1'b1;
            end
         end
         SETUP: begin
            if (tick) begin
               sclk_d  = 1'b1;
               rx_sr_d = {rx_sr[BITS-2:0], miso};
            end
         end
         XFER: begin
            if (tick) begin
               if (!sclk) begin
                  sclk_d  = 1'b1;
                  rx_sr_d = {rx_sr[BITS-2:0], miso};
               end else begin
                  sclk_d = 1'b0;
                  // The final falling edge leaves mosi on the last bit through HOLD.
                  if (!last_bit) begin
                     bit_cnt_d = bit_cnt + 1'b1;
                     tx_sr_d   = {tx_sr[BITS-2:0], 1'b0};
                     mosi_d    = tx_sr[BITS-2];
                  end
               end
            end
         end
         HOLD: begin
            if (tick) begin
               ss_n_d    = 1'b1;
               mosi_d    = 1'b0;
               rx_data_d = rx_sr;
               done_d    = 1'b1;
            end
         end
         GAP: begin
            if (tick) busy_d = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a D=4 instance with a mode-0 slave model and a
// D=1 instance wired in loopback.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, start_f = 1'b0;
   logic [7:0] tx_data = 8'h00, tx_f = 8'h00;
   logic [7:0] rx_data, rx_f;
   logic       busy, done, ss_n, sclk, mosi, miso;
   logic       busy_f, done_f, ss_n_f, sclk_f, mosi_f, miso_f;

   always #5 clk = ~clk;

   spi_master #(.BITS(8), .CLK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start), .txData(tx_data), .rxData(rx_data),
      .busy(busy), .done(done), .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso)
   );

   spi_master #(.BITS(8), .CLK_DIV(1)) dut_fast (
      .clk(clk), .rst(rst), .start(start_f), .txData(tx_f), .rxData(rx_f),
      .busy(busy_f), .done(done_f), .ss_n(ss_n_f), .sclk(sclk_f), .mosi(mosi_f), .miso(miso_f)
   );

   assign miso_f = mosi_f;

   // Slave model and line monitor for the D=4 instance, all sampled on the falling clk edge.
   logic [7:0] slave_word = 8'h00, slave_sr = 8'h00, mosi_cap = 8'h00;
   logic       prev_sclk = 1'b0, prev_ss_n = 1'b1;
   int         cyc = 0, rise_cnt = 0, done_cnt = 0, done_cyc = 0;
   int         ssn_rise_cyc = 0, ssn_fall_cyc = 0;

   assign miso = slave_sr[7];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_sclk <= sclk;
      prev_ss_n <= ss_n;
      if (prev_ss_n && !ss_n) begin
         slave_sr     <= slave_word;
         ssn_fall_cyc <= cyc;
      end else if (prev_sclk && !sclk) begin
         slave_sr <= {slave_sr[6:0], 1'b0};
      end
      if (!prev_ss_n && ss_n) ssn_rise_cyc <= cyc;
      if (!prev_sclk && sclk) begin
         rise_cnt <= rise_cnt + 1;
         mosi_cap <= {mosi_cap[6:0], mosi};
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   int pass_cnt = 0, chk_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int d0, input string name);
      int n = 0;
      while (done_cnt == d0 && n < 300) begin
         step();
         n++;
      end
      check({name, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [7:0] slave;
      logic [7:0] exp_rx;
      logic [7:0] exp_mosi;
      int         exp_lat;
   } vec_t;

   task automatic run_xfer(input vec_t v, input string name);
      int e0, r0, d0;
      r0 = rise_cnt;
      d0 = done_cnt;
      step();
      slave_word = v.slave;
      tx_data    = v.tx;
      start      = 1'b1;
      step();
      start   = 1'b0;
      tx_data = 8'h00;
      e0      = cyc;
      wait_done(d0, name);
      check({name, "_latency"}, 32'(done_cyc - e0), 32'(v.exp_lat));
      check({name, "_rx"}, 32'(rx_data), 32'(v.exp_rx));
      check({name, "_mosi_bits"}, 32'(mosi_cap), 32'(v.exp_mosi));
      check({name, "_sclk_pulses"}, 32'(rise_cnt - r0), 32'd8);
      step();
      check({name, "_done_width"}, 32'(done), 32'd0);
      check({name, "_busy_in_gap"}, 32'(busy), 32'd1);
      repeat (3) step();
      check({name, "_busy_end"}, 32'(busy), 32'd0);
      check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
   endtask

   vec_t vecs[4];

   initial begin
      int e0, e0b, r0, d0, n, rises, first_r, last_r, lat;
      logic prev;

      vecs[0] = '{tx: 8'hA5, slave: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'hA5, exp_lat: 68};
      vecs[1] = '{tx: 8'h00, slave: 8'hFF, exp_rx: 8'hFF, exp_mosi: 8'h00, exp_lat: 68};
      vecs[2] = '{tx: 8'hFF, slave: 8'h00, exp_rx: 8'h00, exp_mosi: 8'hFF, exp_lat: 68};
      vecs[3] = '{tx: 8'h5A, slave: 8'hC3, exp_rx: 8'hC3, exp_mosi: 8'h5A, exp_lat: 68};

      repeat (2) step();
      rst = 1'b0;
      step();
      check("por_ss_n", 32'(ss_n), 32'd1);
      check("por_sclk", 32'(sclk), 32'd0);
      check("por_busy", 32'(busy), 32'd0);
      check("por_rx", 32'(rx_data), 32'd0);

      for (int i = 0; i < 4; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

      // Start pulse with a different word ten cycles into a transfer must be ignored.
      d0 = done_cnt;
      step();
      slave_word = 8'h96;
      tx_data    = 8'h55;
      start      = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      tx_data = 8'hFF;
      start   = 1'b1;
      step();
      start   = 1'b0;
      tx_data = 8'h55;
      wait_done(d0, "ign");
      check("ign_mosi_bits", 32'(mosi_cap), 32'h55);
      check("ign_rx", 32'(rx_data), 32'h96);
      repeat (10) step();
      check("ign_done_count", 32'(done_cnt - d0), 32'd1);
      check("ign_idle_ss_n", 32'(ss_n), 32'd1);

      // Back-to-back: start held high across two transfers.
      d0 = done_cnt;
      step();
      slave_word = 8'h96;
      tx_data    = 8'h12;
      start      = 1'b1;
      step();
      e0      = cyc;
      tx_data = 8'h34;
      wait_done(d0, "b2b_a");
      check("b2b_a_latency", 32'(done_cyc - e0), 32'd68);
      check("b2b_a_mosi_bits", 32'(mosi_cap), 32'h12);
      check("b2b_a_rx", 32'(rx_data), 32'h96);
      slave_word = 8'h69;
      n = 0;
      while (ss_n !== 1'b0 && n < 50) begin
         step();
         n++;
      end
      start = 1'b0;
      e0b   = cyc;
      check("b2b_period", 32'(e0b - e0), 32'd73);
      check("b2b_ss_n_high", 32'(ssn_fall_cyc - ssn_rise_cyc), 32'd5);
      wait_done(d0 + 1, "b2b_b");
      check("b2b_b_latency", 32'(done_cyc - e0b), 32'd68);
      check("b2b_b_mosi_bits", 32'(mosi_cap), 32'h34);
      check("b2b_b_rx", 32'(rx_data), 32'h69);
      repeat (10) step();
      check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

      // Loopback on the D=1 instance.
      step();
      tx_f    = 8'h81;
      start_f = 1'b1;
      step();
      start_f = 1'b0;
      e0      = cyc;
      prev    = sclk_f;
      rises   = 0;
      first_r = 0;
      last_r  = 0;
      lat     = -1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (sclk_f && !prev) begin
            if (rises == 0) first_r = cyc;
            last_r = cyc;
            rises++;
         end
         prev = sclk_f;
         if (done_f) begin
            lat = cyc - e0;
            break;
         end
      end
      check("loop_latency", 32'(lat), 32'd17);
      check("loop_rx", 32'(rx_f), 32'h81);
      check("loop_pulses", 32'(rises), 32'd8);
      check("loop_first_rise", 32'(first_r - e0), 32'd1);
      check("loop_period", 32'(last_r - first_r), 32'd14);

      // Abort after the third sclk rise.
      d0 = done_cnt;
      r0 = rise_cnt;
      step();
      slave_word = 8'hF0;
      tx_data    = 8'h0F;
      start      = 1'b1;
      step();
      start = 1'b0;
      e0    = cyc;
      n     = 0;
      while (rise_cnt - r0 < 3 && n < 100) begin
         step();
         n++;
      end
      check("abort_third_rise", 32'(cyc - e0), 32'd20);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_ss_n", 32'(ss_n), 32'd1);
      check("abort_sclk", 32'(sclk), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_mosi", 32'(mosi), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      repeat (80) step();
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      run_xfer('{tx: 8'hC3, slave: 8'hE7, exp_rx: 8'hE7, exp_mosi: 8'hC3, exp_lat: 68}, "post_abort");

      // Reset for two cycles while idle clears rxData.
      repeat (3) step();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      check("idle_rst_ss_n", 32'(ss_n), 32'd1);
      check("idle_rst_sclk", 32'(sclk), 32'd0);
      check("idle_rst_mosi", 32'(mosi), 32'd0);
      check("idle_rst_busy", 32'(busy), 32'd0);
      check("idle_rst_done", 32'(done), 32'd0);
      check("idle_rst_rx", 32'(rx_data), 32'h00);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
